// File: rtl/glitcher_pkg.sv
// glitcher_pkg: shared reset-behaviour codes, sequencer states and length helper
package glitcher_pkg;
   localparam logic [1:0] RESET_NONE  = 2'b00;
   localparam logic [1:0] RESET_PULSE = 2'b01;
   localparam logic [1:0] RESET_ARM   = 2'b10;
   typedef enum logic [2:0] {S_IDLE, S_RESET, S_ARMED, S_DELAY, S_PULSE, S_GAP} state_t;
   // Counter reload for a length where zero means one cycle
   function automatic logic [15:0] len_m1(input logic [15:0] v);
      return (v == 16'd0) ? 16'd0 : v - 16'd1;
   endfunction
endpackage

// File: rtl/sync_edge_detect.sv
// sync_edge_detect: multi-flop synchronizer with registered one-cycle rising-edge pulse
module sync_edge_detect #(
   parameter int STAGES = 2
) (
   input  logic clk,
   input  logic rst,
   input  logic d,
   output logic pulse
);
   logic [STAGES-1:0] sync;
   logic prev;
   always_ff @(posedge clk) begin
      if (rst) begin
         sync  <= '0;
         prev  <= 1'b0;
         pulse <= 1'b0;
      end else begin
         sync  <= {sync[STAGES-2:0], d};
         prev  <= sync[STAGES-1];
         pulse <= sync[STAGES-1] & ~prev;
      end
   end
endmodule

// File: rtl/glitch_sequencer.sv
// glitch_sequencer: target reset, arm/trigger, delay and glitch pulse train sequencer
module glitch_sequencer
   import glitcher_pkg::*;
#(
   parameter int SYNC_STAGES = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        trigger_i,
   input  logic [15:0] delay_i,
   input  logic [7:0]  width_i,
   input  logic [7:0]  num_pulses_i,
   input  logic [15:0] pulse_spacing_i,
   input  logic [15:0] reset_length_i,
   input  logic [1:0]  reset_behavior_i,
   input  logic        pulse_en_i,
   input  logic        arm_i,
   input  logic        reset_en_i,
   output logic        glitch_o,
   output logic        target_rst_o,
   output logic        armed_o,
   output logic        busy_o,
   output logic        done_o
);
   state_t state, state_n;
   logic [15:0] cnt, cnt_n, s_q, s_n;
   logic [7:0] rem, rem_n, w_q, w_n;
   logic done_n, start, trig;

   sync_edge_detect #(.STAGES(SYNC_STAGES)) u_trig (
      .clk(clk), .rst(rst), .d(trigger_i), .pulse(trig)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state  <= S_IDLE;
         cnt    <= '0;
         rem    <= '0;
         w_q    <= '0;
         s_q    <= '0;
         done_o <= 1'b0;
      end else begin
         state  <= state_n;
         cnt    <= cnt_n;
         rem    <= rem_n;
         w_q    <= w_n;
         s_q    <= s_n;
         done_o <= done_n;
      end
   end

   always_comb begin
      state_n = state;
      cnt_n   = cnt;
      rem_n   = rem;
      w_n     = w_q;
      s_n     = s_q;
      done_n  = 1'b0;
      start   = 1'b0;
      case (state)
         S_IDLE:  if (pulse_en_i) start = 1'b1; else if (arm_i) state_n = S_ARMED;
         S_ARMED: start = pulse_en_i | trig;
         S_RESET: begin
            cnt_n = cnt - 16'd1;
            if (cnt == 16'd0) begin
               start   = reset_behavior_i == RESET_PULSE;
               state_n = (reset_behavior_i == RESET_ARM) ? S_ARMED : S_IDLE;
            end
         end
         S_DELAY: begin
            cnt_n = cnt - 16'd1;
            if (cnt == 16'd0) begin
               state_n = S_PULSE;
               cnt_n   = len_m1({8'd0, w_q});
            end
         end
         S_PULSE: begin
            cnt_n = cnt - 16'd1;
            if (cnt == 16'd0) begin
               state_n = (rem == 8'd1) ? S_IDLE : S_GAP;
               done_n  = rem == 8'd1;
               cnt_n   = len_m1(s_q);
               rem_n   = rem - 8'd1;
            end
         end
         S_GAP: begin
            cnt_n = cnt - 16'd1;
            if (cnt == 16'd0) begin
               state_n = S_PULSE;
               cnt_n   = len_m1({8'd0, w_q});
            end
         end
         default: state_n = S_IDLE;
      endcase
      if (start) begin
         state_n = S_DELAY;
         cnt_n   = delay_i;
         w_n     = width_i;
         s_n     = pulse_spacing_i;
         rem_n   = (num_pulses_i == 8'd0) ? 8'd1 : num_pulses_i;
      end
      // Target reset overrides everything, including a pending done
      if (reset_en_i) begin
         state_n = S_RESET;
         cnt_n   = len_m1(reset_length_i);
         done_n  = 1'b0;
      end
   end

   assign glitch_o     = state == S_PULSE;
   assign target_rst_o = state == S_RESET;
   assign armed_o      = state == S_ARMED;
   assign busy_o       = (state == S_RESET) | (state == S_DELAY) | (state == S_PULSE) | (state == S_GAP);
endmodule
